// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the custom-FP result path.
//   Custom adder format: 1 sign | 6 exponent (bias 31) | 25 fraction, hidden leading 1.
//   Output format: IEEE-754 single (bias 127).
//   fp_convert() turns one adder result plus its status into an IEEE word and
//   {ovf, unf, inexact} flags using round-to-nearest-even.
package fp_pkg;

    localparam int unsigned FP_W        = 32;
    localparam int unsigned FP_EXP_W    = 6;
    localparam int unsigned FP_FRAC_W   = 25;
    localparam int unsigned IEEE_W      = 32;
    localparam int unsigned FLAG_W      = 3;
    localparam int unsigned FP_BIAS_IN  = 31;
    localparam int unsigned FP_BIAS_OUT = 127;

    // Adder stage indicator value meaning "CHECK done, data/status valid".
    localparam logic [2:0] STAGE_CHECK = 3'd4;

    typedef enum logic [3:0] {
        ST_EXACT   = 4'd0,
        ST_OVF     = 4'd1,
        ST_UNF     = 4'd2,
        ST_INEXACT = 4'd3
    } fp_status_t;

    typedef struct packed {
        logic [IEEE_W-1:0] data;
        logic [FLAG_W-1:0] flags; // {ovf, unf, inexact}
    } ieee_res_t;

    // Custom format -> IEEE single. Status codes other than OVF/UNF/INEXACT behave as EXACT.
    function automatic ieee_res_t fp_convert(input logic [FP_W-1:0] d,
                                             input logic [3:0]      status,
                                             input logic [7:0]      bias_delta);
        ieee_res_t               r;
        logic                    s;
        logic [FP_EXP_W-1:0]     e;
        logic [FP_FRAC_W-1:0]    m;
        logic                    round_up;
        logic [23:0]             frac_sum;
        logic [7:0]              e8;

        s = d[FP_W-1];
        e = d[FP_W-2 -: FP_EXP_W];
        m = d[FP_FRAC_W-1:0];

        // Guard is m[1], sticky is m[0], kept LSB is m[2]: ties go to even.
        round_up = m[1] & (m[0] | m[2]);
        frac_sum = {1'b0, m[24:2]} + {23'd0, round_up};
        e8       = {2'b00, e} + bias_delta;

        r.flags = {2'b00, m[1] | m[0] | (status == ST_INEXACT)};
        // Carry out of the fraction means the mantissa became 10.000..., i.e. 1.0 x 2^(e+1).
        if (frac_sum[23]) begin
            r.data = {s, e8 + 8'd1, 23'd0};
        end else begin
            r.data = {s, e8, frac_sum[22:0]};
        end

        if (status == ST_OVF) begin
            r.data  = {s, 8'hFF, 23'd0};
            r.flags = 3'b100;
        end else if (status == ST_UNF) begin
            r.data  = {s, 31'd0};
            r.flags = 3'b010;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_result_fifo.sv
// fp_result_fifo: synchronous FIFO, head presented combinationally.
//   clock_100kHz  in   clock, rising edge
//   reset         in   asynchronous active-low, empties FIFO and clears storage
//   push_i        in   write wdata_i (accepted if not full, or if a pop happens the same edge)
//   pop_i         in   remove head (ignored when empty)
//   wdata_i       in   WIDTH write data
//   rdata_o       out  WIDTH head entry
//   full_o        out  DEPTH entries occupied
//   empty_o       out  no entries occupied
//   count_o       out  occupied entries
module fp_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 35,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock_100kHz,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    // A pop on the same edge frees a slot, so a full FIFO can still accept the push.
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/fp_result_packer.sv
// fp_result_packer: captures each completed custom-FP add, converts it to IEEE-754 single
// with RNE rounding, and queues it for a valid/ready consumer.
//   clock_100kHz  in   clock, rising edge
//   reset         in   asynchronous active-low, clears all state and queued results
//   fp_data_i     in   adder result word
//   fp_status_i   in   adder status: 0 exact, 1 overflow, 2 underflow, 3 inexact
//   fp_stage_i    in   adder stage; entering STAGE_CHECK marks a completed add
//   res_data_o    out  IEEE word at FIFO head
//   res_flags_o   out  {ovf, unf, inexact} at FIFO head
//   res_valid_o   out  FIFO head valid
//   res_ready_i   in   consumer takes head on valid & ready
//   fifo_count_o  out  occupied FIFO entries
//   drop_cnt_o    out  results lost to a full FIFO, saturating at 255
module fp_result_packer
    import fp_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BIAS_IN    = FP_BIAS_IN,
    parameter int unsigned BIAS_OUT   = FP_BIAS_OUT,
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clock_100kHz,
    input  logic              reset,
    input  logic [FP_W-1:0]   fp_data_i,
    input  logic [3:0]        fp_status_i,
    input  logic [2:0]        fp_stage_i,
    output logic [IEEE_W-1:0] res_data_o,
    output logic [FLAG_W-1:0] res_flags_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [CNT_W-1:0]  fifo_count_o,
    output logic [7:0]        drop_cnt_o
);

    localparam logic [7:0] BIAS_DELTA = 8'(BIAS_OUT - BIAS_IN);
    localparam int unsigned RES_W     = IEEE_W + FLAG_W;

    logic [2:0]      stage_prev_q;
    logic            capture;
    logic            cap_valid_q;
    logic [FP_W-1:0] cap_data_q;
    logic [3:0]      cap_status_q;
    logic [7:0]      drop_cnt_q, drop_cnt_d;
    ieee_res_t       conv_res, head_res;
    logic            fifo_full, fifo_empty;
    logic            drop;

    // Only the first cycle of a STAGE_CHECK run counts; a held stage captures once.
    assign capture = (fp_stage_i == STAGE_CHECK) && (stage_prev_q != STAGE_CHECK);

    assign conv_res = fp_convert(cap_data_q, cap_status_q, BIAS_DELTA);

    // Full with no simultaneous pop: the converted result is lost.
    assign drop = cap_valid_q & fifo_full & ~res_ready_i;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            stage_prev_q <= '0;
            cap_valid_q  <= 1'b0;
            cap_data_q   <= '0;
            cap_status_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            stage_prev_q <= fp_stage_i;
            cap_valid_q  <= capture;
            drop_cnt_q   <= drop_cnt_d;
            if (capture) begin
                cap_data_q   <= fp_data_i;
                cap_status_q <= fp_status_i;
            end
        end
    end

    fp_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RES_W)
    ) u_fifo (
        .clock_100kHz (clock_100kHz),
        .reset        (reset),
        .push_i       (cap_valid_q),
        .pop_i        (res_ready_i),
        .wdata_i      (conv_res),
        .rdata_o      (head_res),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (fifo_count_o)
    );

    assign res_data_o  = head_res.data;
    assign res_flags_o = head_res.flags;
    assign res_valid_o = ~fifo_empty;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_fp_result_packer.sv
// Bench for fp_result_packer: directed vectors, a numeric conversion model and a queue
// model of the result FIFO, compared against the DUT on every falling clock edge.
module tb_fp_result_packer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fp_data = '0;
    logic [3:0]  fp_status = '0;
    logic [2:0]  fp_stage = '0;
    logic [31:0] res_data;
    logic [2:0]  res_flags;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [2:0]  fifo_count;
    logic [7:0]  drop_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fp_result_packer #(
        .FIFO_DEPTH (DEPTH),
        .BIAS_IN    (31),
        .BIAS_OUT   (127)
    ) dut (
        .clock_100kHz (clk),
        .reset        (rst_n),
        .fp_data_i    (fp_data),
        .fp_status_i  (fp_status),
        .fp_stage_i   (fp_stage),
        .res_data_o   (res_data),
        .res_flags_o  (res_flags),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .fifo_count_o (fifo_count),
        .drop_cnt_o   (drop_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Value = (2^25 + m) * 2^(e-31-25); re-quantise the 26-bit mantissa to 24 bits with RNE.
    function automatic logic [34:0] model_conv(input logic [31:0] d, input logic [3:0] st);
        logic        s;
        int          ex;
        longint      mant, q, r;
        logic        inex;
        logic [31:0] word;
        s = d[31];
        if (st == 4'd1) return {s, 8'hFF, 23'd0, 3'b100};
        if (st == 4'd2) return {s, 31'd0, 3'b010};
        mant = (longint'(1) << 25) + longint'(d[24:0]);
        q = mant / 4;
        r = mant % 4;
        if (r > 2 || (r == 2 && (q % 2) == 1)) q = q + 1;
        ex = int'(d[30:25]) - 31 + 127;
        if (q == (longint'(1) << 24)) begin
            q = q / 2;
            ex = ex + 1;
        end
        inex = (r != 0) || (st == 4'd3);
        word = {s, 8'(ex), 23'(q - (longint'(1) << 23))};
        return {word, 2'b00, inex};
    endfunction

    // Transaction model: a completion is pushed one edge after it is seen, the head
    // is popped on valid & ready, and a push into a full queue without a pop is dropped.
    logic [34:0] mq[$];
    int          m_drop = 0;
    bit          m_pend = 1'b0;
    logic [34:0] m_item = '0;
    logic [2:0]  m_prev = '0;

    always @(posedge clk or negedge rst_n) begin : model
        int sz;
        bit pop;
        if (!rst_n) begin
            mq.delete();
            m_drop = 0;
            m_pend = 1'b0;
            m_prev = '0;
        end else begin
            sz  = mq.size();
            pop = (sz > 0) && res_ready;
            if (pop) void'(mq.pop_front());
            if (m_pend) begin
                if (sz == DEPTH && !pop) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    mq.push_back(m_item);
                end
            end
            m_pend = (fp_stage == 3'd4) && (m_prev != 3'd4);
            if (m_pend) m_item = model_conv(fp_data, fp_status);
            m_prev = fp_stage;
        end
    end

    always @(negedge clk) begin : compare
        logic [34:0] h;
        check("cmp_valid", {31'd0, res_valid}, {31'd0, mq.size() > 0});
        check("cmp_count", {29'd0, fifo_count}, 32'(mq.size()));
        check("cmp_drop", {24'd0, drop_cnt}, 32'(m_drop));
        if (mq.size() > 0) begin
            h = mq[0];
            check("cmp_data", res_data, h[34:3]);
            check("cmp_flags", {29'd0, res_flags}, {29'd0, h[2:0]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] st);
        fp_data   = d;
        fp_status = st;
        fp_stage  = 3'd4;
        tick();
        fp_stage = 3'd0;
        repeat (5) tick();
    endtask

    task automatic pin(input string name, input logic [31:0] d, input logic [3:0] st,
                       input logic [31:0] exp_data, input logic [2:0] exp_flags);
        logic [34:0] r;
        r = model_conv(d, st);
        check({name, "_data"}, r[34:3], exp_data);
        check({name, "_flags"}, {29'd0, r[2:0]}, {29'd0, exp_flags});
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_data"}, res_data, 32'h0);
        check({name, "_flags"}, {29'd0, res_flags}, 32'h0);
        check({name, "_valid"}, {31'd0, res_valid}, 32'h0);
        check({name, "_count"}, {29'd0, fifo_count}, 32'h0);
        check({name, "_drop"}, {24'd0, drop_cnt}, 32'h0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Hand-computed conversions pinning the model.
        pin("pin_one",   {1'b0, 6'd31, 25'h0},       4'd0, 32'h3F80_0000, 3'b000);
        pin("pin_tie",   {1'b0, 6'd31, 25'h0000002}, 4'd0, 32'h3F80_0000, 3'b001);
        pin("pin_carry", {1'b0, 6'd31, 25'h1FFFFFE}, 4'd0, 32'h4000_0000, 3'b001);
        pin("pin_up",    {1'b0, 6'd31, 25'h0000006}, 4'd0, 32'h3F80_0002, 3'b001);
        pin("pin_ovf",   {1'b1, 6'd10, 25'h123},     4'd1, 32'hFF80_0000, 3'b100);
        pin("pin_unf",   {1'b0, 6'd10, 25'h123},     4'd2, 32'h0000_0000, 3'b010);

        // Latency: head appears exactly two cycles after the stage-4 cycle.
        res_ready = 1'b0;
        fp_data   = {1'b0, 6'd31, 25'h0};
        fp_status = 4'd0;
        fp_stage  = 3'd4;
        @(negedge clk);
        check("lat_c0_valid", {31'd0, res_valid}, 32'h0);
        tick();
        fp_stage = 3'd0;
        @(negedge clk);
        check("lat_c1_valid", {31'd0, res_valid}, 32'h0);
        tick();
        @(negedge clk);
        check("lat_c2_valid", {31'd0, res_valid}, 32'h1);
        check("lat_c2_data", res_data, 32'h3F80_0000);
        check("lat_c2_flags", {29'd0, res_flags}, 32'h0);
        tick();
        res_ready = 1'b1;
        repeat (3) tick();

        // Conversion vectors streamed through an always-ready consumer.
        send({1'b0, 6'd31, 25'h0000002}, 4'd0);
        send({1'b0, 6'd31, 25'h1FFFFFE}, 4'd0);
        send({1'b1, 6'd20, 25'h0ABCDEF}, 4'd1);
        send({1'b0, 6'd20, 25'h0ABCDEF}, 4'd2);
        send({1'b1, 6'd40, 25'h1000000}, 4'd3);
        send({1'b0, 6'd0,  25'h0000007}, 4'd7);
        send({1'b1, 6'd63, 25'h0000005}, 4'd0);
        send({1'b0, 6'd31, 25'h0000006}, 4'd15);

        // Overflow the FIFO: four kept, two dropped, then drained in order.
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send({1'b0, 6'(30 + i), 25'(i * 3)}, 4'd0);
        end
        check("full_count", {29'd0, fifo_count}, 32'd4);
        check("full_drop", {24'd0, drop_cnt}, 32'd2);
        res_ready = 1'b1;
        repeat (6) tick();
        check("drain_valid", {31'd0, res_valid}, 32'h0);
        check("drain_count", {29'd0, fifo_count}, 32'h0);

        // Held stage 4 captures once.
        res_ready = 1'b0;
        fp_data   = {1'b0, 6'd33, 25'h0000003};
        fp_status = 4'd0;
        fp_stage  = 3'd4;
        repeat (5) tick();
        fp_stage = 3'd0;
        repeat (4) tick();
        check("held_count", {29'd0, fifo_count}, 32'd1);

        // Reset with three entries queued discards everything at once.
        send({1'b1, 6'd31, 25'h0}, 4'd0);
        send({1'b0, 6'd32, 25'h0}, 4'd0);
        check("preq_count", {29'd0, fifo_count}, 32'd3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        tick();
        rst_n     = 1'b1;
        res_ready = 1'b1;
        repeat (10) tick();
        check("post_valid", {31'd0, res_valid}, 32'h0);
        check("post_count", {29'd0, fifo_count}, 32'h0);

        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
